// File: rtl/bandeja_param.sv
// Parametrised cork tray: binary + BCD count, incremental refill, status flags.
// Optional one-deep refill queue enabled by defining BANDEJA_REFILL_QUEUE_EN.
//
// state  | meaning
// IDLE   | serving consume requests, accepting refill requests
// REFILL | adding one cork per cycle until remainder is spent or tray is full
module bandeja_param #(
  parameter int CAPACITY   = 99,
  parameter int REFILL_AMT = 20,
  parameter int LOW_THRESH = 5,
  parameter int INIT_COUNT = 20
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            consumir,
  input  logic                            reabastecer,
  output logic                            rolha_ok,
  output logic                            ocupado,
  output logic                            CR,
  output logic                            BZ,
  output logic                            cheio,
  output logic [$clog2(CAPACITY+1)-1:0]   contagem,
  output logic [3:0]                      unidades_bandeja,
  output logic [3:0]                      dezenas_bandeja,
  output logic [3:0]                      centenas_bandeja
);

  localparam int CW = $clog2(CAPACITY + 1);
  localparam logic [CW-1:0] CAP_C  = CW'(CAPACITY);
  localparam logic [CW-1:0] CAP_M1 = CW'(CAPACITY - 1);
  localparam logic [CW-1:0] AMT_C  = CW'(REFILL_AMT);
  localparam logic [CW-1:0] LOW_C  = CW'(LOW_THRESH);
  localparam logic [CW-1:0] INIT_C = CW'(INIT_COUNT);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  // Reset digits are elaboration-time constants; no runtime conversion exists.
  localparam logic [11:0] INIT_BCD = {4'(INIT_COUNT / 100), 4'((INIT_COUNT / 10) % 10),
                                      4'(INIT_COUNT % 10)};

  typedef enum logic {IDLE, REFILL} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [11:0]   bcd_q, bcd_d;
  logic          rolha_ok_q, rolha_ok_d;
`ifdef BANDEJA_REFILL_QUEUE_EN
  logic          pend_q, pend_d;
`endif

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[7:4] == 4'd9) begin
        r[7:4]  = 4'd0;
        r[11:8] = v[11:8] + 4'd1;
      end else begin
        r[7:4] = v[7:4] + 4'd1;
      end
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [11:0] r;
    r = v;
    if (v[3:0] == 4'd0) begin
      r[3:0] = 4'd9;
      if (v[7:4] == 4'd0) begin
        r[7:4]  = 4'd9;
        r[11:8] = v[11:8] - 4'd1;
      end else begin
        r[7:4] = v[7:4] - 4'd1;
      end
    end else begin
      r[3:0] = v[3:0] - 4'd1;
    end
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rem_d      = rem_q;
    bcd_d      = bcd_q;
    rolha_ok_d = 1'b0;
`ifdef BANDEJA_REFILL_QUEUE_EN
    pend_d     = pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (reabastecer && (count_q != CAP_C)) begin
          state_d = REFILL;
          rem_d   = AMT_C;
        end else if (consumir && (count_q != '0)) begin
          count_d    = count_q - ONE_C;
          bcd_d      = bcd_dec(bcd_q);
          rolha_ok_d = 1'b1;
        end
      end
      REFILL: begin
        count_d = count_q + ONE_C;
        bcd_d   = bcd_inc(bcd_q);
        rem_d   = rem_q - ONE_C;
`ifdef BANDEJA_REFILL_QUEUE_EN
        pend_d  = pend_q | reabastecer;
`endif
        if ((rem_q == ONE_C) || (count_q == CAP_M1)) begin
`ifdef BANDEJA_REFILL_QUEUE_EN
          // A queued request re-arms the refill only if room remains after this increment.
          if (pend_d && (count_q != CAP_M1)) begin
            rem_d = AMT_C;
          end else begin
            state_d = IDLE;
          end
          pend_d = 1'b0;
`else
          state_d = IDLE;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= INIT_C;
      rem_q      <= '0;
      bcd_q      <= INIT_BCD;
      rolha_ok_q <= 1'b0;
`ifdef BANDEJA_REFILL_QUEUE_EN
      pend_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
      bcd_q      <= bcd_d;
      rolha_ok_q <= rolha_ok_d;
`ifdef BANDEJA_REFILL_QUEUE_EN
      pend_q     <= pend_d;
`endif
    end
  end

  assign rolha_ok         = rolha_ok_q;
  assign ocupado          = (state_q == REFILL);
  assign contagem         = count_q;
  assign BZ               = (count_q == '0);
  assign CR               = (count_q != '0) && (count_q <= LOW_C);
  assign cheio            = (count_q == CAP_C);
  assign unidades_bandeja = bcd_q[3:0];
  assign dezenas_bandeja  = bcd_q[7:4];
  assign centenas_bandeja = bcd_q[11:8];

endmodule

// File: doc/bandeja_param.md
Name: bandeja_param

Overview:
- Parametrised cork-tray model: next generation of the bottling-line tray counter.
- Holds a cork count with configurable capacity, refill amount and low-level threshold.
- Serves one cork per consume request and refills incrementally over several cycles.
- Drives BCD digits for the display path and the CR/BZ status flags consumed by the line controller FSM.

Parameters:
- CAPACITY, 99, maximum cork count (1..999).
- REFILL_AMT, 20, corks added per refill request (1..CAPACITY).
- LOW_THRESH, 5, CR asserts when 0 < count <= LOW_THRESH (< CAPACITY).
- INIT_COUNT, 20, count loaded at reset (0..CAPACITY).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- consumir  input  1  request to take one cork; sampled every cycle.
- reabastecer  input  1  request to add REFILL_AMT corks; sampled every cycle.
- rolha_ok  output  1  registered one-cycle pulse: cork delivered.
- ocupado  output  1  high while a refill is in progress.
- CR  output  1  low-level flag.
- BZ  output  1  empty flag (count == 0).
- cheio  output  1  full flag (count == CAPACITY).
- contagem  output  $clog2(CAPACITY+1)  binary cork count.
- unidades_bandeja  output  4  BCD units of count.
- dezenas_bandeja  output  4  BCD tens of count.
- centenas_bandeja  output  4  BCD hundreds of count.

Behaviour:
- Reset (synchronous, active-high) sets:
  - count = INIT_COUNT, state = IDLE, refill remainder = 0, rolha_ok = 0.
  - BCD digits are loaded with the BCD value of INIT_COUNT.
  - Reset overrides every other input in the same cycle, including a refill in progress, which is aborted.
- Count storage: count is held in binary and in three BCD digit registers, updated together.
  - BCD decrement: borrow from 0 to 9 ripples into the next digit.
  - BCD increment: carry from 9 to 0 ripples into the next digit.
  - No binary-to-BCD conversion logic.
- Flags are combinational from the registered count, so they are valid in the same cycle as contagem.
  - BZ = (count == 0).
  - CR = (count != 0) and (count <= LOW_THRESH).
  - cheio = (count == CAPACITY).
- FSM states: IDLE, REFILL.
- IDLE, evaluated in priority order:
  - reabastecer=1 and count < CAPACITY: go to REFILL; remainder = REFILL_AMT; consumir in this cycle is ignored (no decrement, no rolha_ok).
  - reabastecer=1 and count == CAPACITY: no action; consumir in the same cycle is then served normally.
  - consumir=1 and count > 0: count decrements by 1; rolha_ok = 1 in the next cycle, coincident with the new count.
  - consumir=1 and count == 0: no change; rolha_ok stays 0.
  - Holding consumir high gives one cork per cycle until empty.
- REFILL:
  - ocupado = 1.
  - Each cycle: count increments by 1 and remainder decrements by 1.
  - Return to IDLE after the increment that makes remainder 0 or count == CAPACITY, whichever comes first (saturation; excess corks are discarded).
  - consumir is ignored, with rolha_ok = 0.
  - reabastecer is ignored unless REFILL_QUEUE_EN is defined.
- Latency:
  - A full refill of N corks takes N cycles in REFILL.
  - ocupado falls in the cycle after the last increment.
  - First consumption can be accepted in the cycle ocupado is low.
- contagem never exceeds CAPACITY and never underflows below 0.

Optional Feature:
- Macro: BANDEJA_REFILL_QUEUE_EN.
- Defined:
  - A one-deep pending-refill flag is set when reabastecer=1 during REFILL.
  - On exit from REFILL with the flag set, the block goes straight back to REFILL with remainder = REFILL_AMT, if count < CAPACITY; the flag clears.
  - If count == CAPACITY on exit, the flag clears with no action.
  - Additional requests while the flag is set are dropped.
  - Reset clears the flag.
- Not defined: reabastecer during REFILL is discarded; no pending-refill storage exists.

Test Plan:
- Reset with defaults -> contagem=20, digits 0/2/0, CR=0, BZ=0, cheio=0, ocupado=0, rolha_ok=0.
- consumir held high for 20 cycles from 20 -> 20 rolha_ok pulses; CR rises at count 5; BZ rises at count 0; a 21st request gives no rolha_ok and count stays 0. Check BCD borrow at 10->9 (digits 9/0/0).
- From 0, single reabastecer pulse -> ocupado high 20 cycles; count 0..20 one per cycle; digits 0/2/0 at end; consumir during refill produces no rolha_ok.
- CAPACITY=99, count 90, reabastecer -> 9 increments, stops at 99, cheio=1, ocupado low after 9 cycles. A further reabastecer with consumir in the same cycle -> no refill, count 98, rolha_ok.
- reset asserted mid-refill at count 7 -> next cycle count=20, state IDLE, ocupado=0.
- With BANDEJA_REFILL_QUEUE_EN, two reabastecer pulses 3 cycles apart from 0 -> back-to-back refills, count 40, ocupado high 40 consecutive cycles. Without the macro -> count 20.
